seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver placed directly downstream of the binary-to-BCD converter. It takes the packed BCD score, latches it once per scan frame so a digit never tears mid-frame, and scans the digits one at a time with registered segment and anode outputs. The scan adds a dead cycle at the start of every digit slot to suppress ghosting, and blanks invalid nibbles with a dash pattern.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 tb/tb_seg7_scan_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: BCD digit type and
// active-high segment patterns (bit 0 = segment a, bit 6 = segment g).
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-high segment pattern; non-decimal nibbles map to a dash.
// Combinational, no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-frame BCD latch; SEG7_LZB_EN enables leading-zero blanking.
// Latency: seg/an/frame_tick registered, 1 cycle after div/idx/disp/blank.
// Backpressure: none; bcd is sampled only at the frame boundary, scan free-runs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_UNLIT = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_IDLE   = {DIGITS{AN_ACTIVE_LOW}};

    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] disp;

    logic                div_wrap;
    logic                frame_end;
    bcd_digit_t          cur_digit;
    logic [6:0]          pattern;
    logic                lz_dark;
    logic                lit;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;
    logic                frame_nxt;

    assign div_wrap  = (div == DIV_LAST);
    assign frame_end = div_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            idx  <= '0;
            disp <= '0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                disp <= bcd;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = disp[4*i +: 4];
            end
        end
    end

    seg7_decode u_decode (
        .digit   (cur_digit),
        .pattern (pattern)
    );

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] zeros_above;
    logic              zero_run;

    // zeros_above[i]: nibbles i..DIGITS-1 are all zero; A-F count as non-zero.
    always_comb begin
        zeros_above = '0;
        zero_run    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run       = zero_run && (disp[4*i +: 4] == 4'd0);
            zeros_above[i] = zero_run;
        end
        lz_dark = (idx != '0) && zeros_above[idx];
    end
`else
    assign lz_dark = 1'b0;
`endif

    // div==0 is the anti-ghosting dead cycle at the start of every slot.
    assign lit       = (div != '0) && !blank && !lz_dark;
    assign seg_nxt   = (lit ? pattern : SEG_OFF) ^ {7{SEG_ACTIVE_LOW}};
    assign an_nxt    = (lit ? (DIGITS'(1) << idx) : '0) ^ {DIGITS{AN_ACTIVE_LOW}};
    assign frame_nxt = (div == '0) && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_UNLIT;
            an         <= AN_IDLE;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: active-low and active-high instances, per-cycle scoreboard plus directed checks.
module tb_seg7_scan_driver;

    localparam int DG    = 3;
    localparam int SD    = 4;
    localparam int FRAME = DG * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] bcd;
    logic        blank;
    logic [6:0]  seg_l, seg_h;
    logic [2:0]  an_l, an_h;
    logic        ft_l, ft_h;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [6:0] seg_l;
        logic [2:0] an_l;
        logic [6:0] seg_h;
        logic [2:0] an_h;
        logic       ft;
    } exp_t;

    exp_t sb[$];
    int          ph;
    logic [11:0] mdisp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank),
        .seg(seg_l), .an(an_l), .frame_tick(ft_l)
    );

    seg7_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank),
        .seg(seg_h), .an(an_h), .frame_tick(ft_h)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [6:0] seg_pat(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected outputs one cycle after the scan sits at frame position p.
    function automatic exp_t model_out(input int p, input logic [11:0] d, input logic blk);
        exp_t       e;
        int         dig;
        int         off;
        logic       dark;
        logic [6:0] pat;
        logic [2:0] oh;
        dig  = p / SD;
        off  = p % SD;
        dark = (off == 0) || blk;
`ifdef SEG7_LZB_EN
        if (dig > 0 && (d >> (4 * dig)) == 12'd0) dark = 1'b1;
`endif
        pat     = dark ? 7'h00 : seg_pat(d[dig*4 +: 4]);
        oh      = dark ? 3'b000 : 3'(1 << dig);
        e.seg_h = pat;
        e.an_h  = oh;
        e.seg_l = ~pat;
        e.an_l  = ~oh;
        e.ft    = (p == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            ph    = 0;
            mdisp = '0;
        end else begin
            sb.push_back(model_out(ph, mdisp, blank));
            if (ph == FRAME - 1) mdisp = bcd;
            ph = (ph + 1) % FRAME;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            check_val("rst_seg_l", seg_l, 7'h7F);
            check_val("rst_an_l",  an_l,  3'b111);
            check_val("rst_ft",    ft_l,  1'b0);
            check_val("rst_seg_h", seg_h, 7'h00);
            check_val("rst_an_h",  an_h,  3'b000);
        end else if (sb.size() == 0) begin
            check_val("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_val("sb_seg_l", seg_l, e.seg_l);
            check_val("sb_an_l",  an_l,  e.an_l);
            check_val("sb_seg_h", seg_h, e.seg_h);
            check_val("sb_an_h",  an_h,  e.an_h);
            check_val("sb_ft",    ft_l,  e.ft);
            check_val("sb_ft_h",  ft_h,  e.ft);
        end
    end

    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ft_l !== 1'b1 && k < 4 * FRAME);
        if (ft_l !== 1'b1) check_val("tick_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bcd   = 12'h000;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        check_val("init_seg", seg_l, 7'h7F);
        check_val("init_an",  an_l,  3'b111);
        check_val("init_ft",  ft_l,  1'b0);

        // Release and walk the first slots.
        rst_n = 1'b1;
        @(negedge clk);
        check_val("first_ft",   ft_l, 1'b1);
        check_val("first_dark", an_l, 3'b111);
        @(negedge clk);
        check_val("d0_an", an_l, 3'b110);
        repeat (3) @(negedge clk);
        check_val("d1_dark", an_l, 3'b111);
        @(negedge clk);
        check_val("d1_an", an_l, 3'b101);
        repeat (7) @(negedge clk);
        check_val("ft_period", ft_l, 1'b1);

        // 042: digits 2 and 4, leading zero on digit 2.
        bcd = 12'h042;
        wait_tick();
        wait_tick();
        @(negedge clk);
        check_val("d0_two", seg_l, 7'h24);
        repeat (4) @(negedge clk);
        check_val("d1_four", seg_l, 7'h19);
        repeat (4) @(negedge clk);
`ifdef SEG7_LZB_EN
        check_val("d2_lzb_an", an_l, 3'b111);
`else
        check_val("d2_zero_seg", seg_l, 7'h40);
        check_val("d2_zero_an",  an_l,  3'b011);
`endif

        // 123 -> 456 mid-frame: no tearing.
        bcd = 12'h123;
        wait_tick();
        wait_tick();
        repeat (3) @(negedge clk);
        bcd = 12'h456;
        repeat (3) @(negedge clk);
        check_val("tear_d1", seg_l, 7'h24);
        repeat (3) @(negedge clk);
        check_val("tear_d2", seg_l, 7'h79);
        wait_tick();
        @(negedge clk);
        check_val("new_d0", seg_l, 7'h02);

        // Invalid nibble on digit 1 shows a dash.
        bcd = 12'h0B0;
        wait_tick();
        wait_tick();
        repeat (5) @(negedge clk);
        check_val("dash_seg", seg_l, 7'b0111111);
        check_val("dash_an",  an_l,  3'b101);

        // Active-high instance.
        bcd = 12'h008;
        wait_tick();
        wait_tick();
        @(negedge clk);
        check_val("pol_seg_h", seg_h, 7'h7F);
        check_val("pol_an_h",  an_h,  3'b001);
        check_val("pol_seg_l", seg_l, 7'h00);
        check_val("pol_an_l",  an_l,  3'b110);

        // Blank for 20 cycles while a new value is latched underneath.
        bcd   = 12'h777;
        blank = 1'b1;
        @(negedge clk);
        check_val("blank_an", an_l, 3'b111);
        repeat (19) @(negedge clk);
        blank = 1'b0;
        wait_tick();
        @(negedge clk);
        check_val("blank_load", seg_l, 7'h78);

        // Asynchronous reset in the middle of digit 1.
        wait_tick();
        repeat (5) @(negedge clk);
        check_val("pre_rst_an", an_l, 3'b101);
        rst_n = 1'b0;
        #1;
        check_val("arst_seg", seg_l, 7'h7F);
        check_val("arst_an",  an_l,  3'b111);
        check_val("arst_anh", an_h,  3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_restart_ft", ft_l, 1'b1);
        @(negedge clk);
        check_val("rst_disp0_seg", seg_l, 7'h40);
        check_val("rst_disp0_an",  an_l,  3'b110);

        repeat (30) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
